ifetch: RTL and testbench

Instruction fetch stage directly downstream of the L1 instruction cache. Owns the program counter, drives it to the cache, captures the returned instruction word into the IF/ID pipeline register and computes the sequential next PC from the instruction length. Handles redirects (branch, jump, trap) that arrive while a cache miss is in flight, holding the PC stable until the cache is ready. Applies decode-stage backpressure by freezing the PC.

---
 rtl/ifetch.sv | 109 ++++++++++
 tb/tb_ifetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch: PC owner and IF/ID register behind the I-cache; RVC_EN enables 16-bit compressed fetch
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] pc,
    input  logic [31:0] ir,
    input  logic        stall_imem,
    output logic        imem_stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_ir,
    output logic        if_ilen,
    output logic        if_illegal
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIR} state_t;
    state_t state_q, state_d;
    logic [63:0] pc_q, pc_d, pend_q, pend_d, if_pc_q, if_pc_d, tgt, inc;
    logic [31:0] if_ir_q, if_ir_d, cap_ir;
    logic if_valid_q, if_valid_d, if_ilen_q, if_ilen_d, if_illegal_q, if_illegal_d;
    logic len32, cap, cap_ilen, cap_ill;
    assign len32 = ir[1:0] == 2'b11;
`ifdef RVC_EN
    assign tgt      = redirect_pc & ~64'h1;
    assign inc      = len32 ? 64'd4 : 64'd2;
    assign cap_ir   = len32 ? ir : {16'b0, ir[15:0]};
    assign cap_ilen = len32;
    assign cap_ill  = 1'b0;
`else
    assign tgt      = redirect_pc & ~64'h3;
    assign inc      = 64'd4;
    assign cap_ir   = ir;
    assign cap_ilen = 1'b1;
    assign cap_ill  = !len32;
`endif
    assign cap = state_q == S_RUN && !stall_imem && (!if_valid_q || !id_stall) && !redirect;
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        if_pc_d      = if_pc_q;
        if_ir_d      = if_ir_q;
        if_valid_d   = if_valid_q;
        if_ilen_d    = if_ilen_q;
        if_illegal_d = if_illegal_q;
        if (cap) begin
            if_ir_d      = cap_ir;
            if_pc_d      = pc_q;
            if_valid_d   = 1'b1;
            if_ilen_d    = cap_ilen;
            if_illegal_d = cap_ill;
            pc_d         = pc_q + inc;
        end else if (!id_stall) begin
            if_valid_d = 1'b0;
        end
        // A redirect during a miss is parked so the cache address stays stable
        if (state_q != S_REDIR && redirect) begin
            if_valid_d = 1'b0;
            if (!stall_imem) begin
                pc_d    = tgt;
                state_d = S_RUN;
            end else begin
                pend_d  = tgt;
                state_d = S_REDIR;
            end
        end else if (state_q == S_BOOT) begin
            state_d = S_RUN;
        end else if (state_q == S_REDIR) begin
            if_valid_d = 1'b0;
            if (redirect) pend_d = tgt;
            if (!stall_imem) begin
                pc_d    = redirect ? tgt : pend_q;
                state_d = S_RUN;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            if_pc_q      <= '0;
            if_ir_q      <= '0;
            if_valid_q   <= 1'b0;
            if_ilen_q    <= 1'b1;
            if_illegal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            if_pc_q      <= if_pc_d;
            if_ir_q      <= if_ir_d;
            if_valid_q   <= if_valid_d;
            if_ilen_q    <= if_ilen_d;
            if_illegal_q <= if_illegal_d;
        end
    end
    assign pc         = pc_q;
    assign if_pc      = if_pc_q;
    assign if_ir      = if_ir_q;
    assign if_valid   = if_valid_q;
    assign if_ilen    = if_ilen_q;
    assign if_illegal = if_illegal_q;
    assign imem_stall = if_valid_q && id_stall;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch
module tb_ifetch;
    logic        clk = 0, rst_n = 0, stall_imem = 0, redirect = 0, id_stall = 0;
    logic [31:0] ir = 32'h13;
    logic [63:0] redirect_pc = '0;
    logic [63:0] pc, if_pc;
    logic [31:0] if_ir;
    logic        imem_stall, if_valid, if_ilen, if_illegal;
    int total = 0, bad = 0;
    logic [63:0] p;

    ifetch dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ir(ir), .stall_imem(stall_imem),
        .imem_stall(imem_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_stall(id_stall), .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir),
        .if_ilen(if_ilen), .if_illegal(if_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick; tick;
        check("rst_pc", pc, 64'h8000_0000);
        check("rst_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_ir", if_ir, 0);
        check("rst_ilen", if_ilen, 1);
        check("rst_illegal", if_illegal, 0);
        check("rst_imem_stall", imem_stall, 0);
        rst_n = 1;
        tick;
        check("boot_pc", pc, 64'h8000_0000);
        check("boot_valid", if_valid, 0);
        tick;
        check("seq1_pc", pc, 64'h8000_0004);
        check("seq1_if_pc", if_pc, 64'h8000_0000);
        check("seq1_valid", if_valid, 1);
        check("seq1_if_ir", if_ir, 32'h13);
        tick;
        check("seq2_pc", pc, 64'h8000_0008);
        check("seq2_if_pc", if_pc, 64'h8000_0004);
        redirect = 1; redirect_pc = 64'h8000_0010;
        tick;
        redirect = 0;
        check("redir_pc", pc, 64'h8000_0010);
        check("redir_valid", if_valid, 0);
        ir = 32'h0000_4501;
        tick;
        check("c_if_pc", if_pc, 64'h8000_0010);
        check("c_valid", if_valid, 1);
        check("c_if_ir", if_ir, 32'h0000_4501);
`ifdef RVC_EN
        check("c_ilen", if_ilen, 0);
        check("c_illegal", if_illegal, 0);
        check("c_pc", pc, 64'h8000_0012);
        p = 64'h8000_0012;
`else
        check("c_ilen", if_ilen, 1);
        check("c_illegal", if_illegal, 1);
        check("c_pc", pc, 64'h8000_0014);
        p = 64'h8000_0014;
`endif
        ir = 32'h13; stall_imem = 1;
        tick;
        check("miss1_pc", pc, p);
        check("miss1_valid", if_valid, 0);
        redirect = 1; redirect_pc = 64'h8000_1000;
        tick;
        redirect = 0;
        check("miss2_pc", pc, p);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("miss_hold_pc", pc, p);
            check("miss_hold_valid", if_valid, 0);
        end
        stall_imem = 0; ir = 32'hDEAD_BEEF;
        tick;
        check("miss_end_pc", pc, 64'h8000_1000);
        check("miss_end_valid", if_valid, 0);
        ir = 32'h13;
        tick;
        check("post_miss_if_pc", if_pc, 64'h8000_1000);
        check("post_miss_if_ir", if_ir, 32'h13);
        check("post_miss_pc", pc, 64'h8000_1004);
        stall_imem = 1; redirect = 1; redirect_pc = 64'h100;
        tick;
        redirect_pc = 64'h200;
        tick;
        redirect = 0;
        check("dbl_hold_pc", pc, 64'h8000_1004);
        stall_imem = 0;
        tick;
        check("dbl_pc", pc, 64'h200);
        tick;
        check("dbl_if_pc", if_pc, 64'h200);
        check("dbl_next_pc", pc, 64'h204);
        id_stall = 1; ir = 32'h0010_0093;
        #1;
        check("bp_imem_stall0", imem_stall, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("bp_pc", pc, 64'h204);
            check("bp_if_pc", if_pc, 64'h200);
            check("bp_if_ir", if_ir, 32'h13);
            check("bp_valid", if_valid, 1);
            check("bp_imem_stall", imem_stall, 1);
        end
        id_stall = 0;
        #1;
        check("rel_imem_stall", imem_stall, 0);
        tick;
        check("rel_if_pc", if_pc, 64'h204);
        check("rel_if_ir", if_ir, 32'h0010_0093);
        check("rel_pc", pc, 64'h208);
        id_stall = 1; redirect = 1; redirect_pc = 64'h301;
        tick;
        check("flush_pc", pc, 64'h300);
        check("flush_valid", if_valid, 0);
        check("flush_imem_stall", imem_stall, 0);
        id_stall = 0; redirect_pc = 64'h403;
        tick;
`ifdef RVC_EN
        check("align_pc", pc, 64'h402);
`else
        check("align_pc", pc, 64'h400);
`endif
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick;
        redirect = 0; ir = 32'h13;
        check("wrap_start_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick;
        check("wrap_pc", pc, 64'h0);
        check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        redirect = 1; redirect_pc = 64'h500; ir = 32'h0020_0113;
        tick;
        check("rc_pc", pc, 64'h500);
        check("rc_valid", if_valid, 0);
        check("rc_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        stall_imem = 1; redirect_pc = 64'h600;
        tick;
        redirect = 0;
        check("rm_hold_pc", pc, 64'h500);
        rst_n = 0;
        tick;
        check("rm_rst_pc", pc, 64'h8000_0000);
        check("rm_rst_valid", if_valid, 0);
        rst_n = 1; stall_imem = 0; ir = 32'h13;
        tick;
        check("rm_boot_pc", pc, 64'h8000_0000);
        tick;
        check("rm_run_pc", pc, 64'h8000_0004);
        check("rm_run_if_pc", if_pc, 64'h8000_0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
